// File: rtl/fir_stream_if.sv
// -----------------------------------------------------------------------------
// fir_stream_if
//
// Groups the input sample stream, the output sample stream and the
// coefficient register port of fir_stream into a single bundle.
//
// Signals:
//   in_data    [DATA_W]  signed input sample
//   in_valid             in_data is valid
//   in_ready             filter can accept a sample
//   out_data   [DATA_W]  signed filtered sample
//   out_valid            out_data is valid
//   out_ready            downstream accepts out_data
//   coef_we              coefficient write strobe
//   coef_addr  [AW]      coefficient index
//   coef_data  [COEF_W]  signed coefficient value
//
// Modports:
//   master - the side that feeds samples, drains results and programs taps
//   slave  - the filter itself
// -----------------------------------------------------------------------------
interface fir_stream_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16
);
  localparam int AW = $clog2(TAPS);

  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;

  modport master (
    output in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fir_stream.sv
// -----------------------------------------------------------------------------
// fir_stream
//
// Runtime-programmable single-channel FIR filter built around one
// time-shared multiply-accumulate. Each accepted sample is shifted into a
// TAPS-deep delay line, then TAPS MAC cycles form the dot product with the
// coefficient bank, the accumulator is scaled by FRAC and saturated to
// DATA_W, and the result is held on the output until it is taken.
//
// Ports:
//   ck     - clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset (clears FSM, delay line,
//            coefficients, accumulator, counter and output register)
//   bus    - fir_stream_if.slave: input stream, output stream and
//            coefficient write port
//   busy   - high in every state except IDLE
//
// Build option:
//   FIR_STREAM_ROUND_EN - when defined, the output is rounded half up
//   before the shift instead of truncated toward minus infinity. Latency
//   and handshake are the same in both builds.
// -----------------------------------------------------------------------------
module fir_stream #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int FRAC   = 15
) (
  input  logic        ck,
  input  logic        rst_n,
  fir_stream_if.slave bus,
  output logic        busy
);

  localparam int AW     = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + AW;
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_L   = (AW + 1)'(TAPS);

  // Saturation bounds expressed at the width of the scaled accumulator.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

`ifdef FIR_STREAM_ROUND_EN
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) << (FRAC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    SAVE = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [DATA_W-1:0] smp  [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            cnt;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    pre_shift;
  logic signed [ACC_W:0]    scaled;
  logic signed [DATA_W-1:0] sat_val;
  logic                     coef_wr;

  // ---------------------------------------------------------------------------
  // Status and handshake outputs decode directly from the registered state.
  // ---------------------------------------------------------------------------
  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // Writes are only honoured while idle; a write in the same cycle a sample
  // is accepted therefore lands before the first MAC cycle reads the bank.
  assign coef_wr = (state == IDLE) && bus.coef_we &&
                   ({1'b0, bus.coef_addr} < TAPS_L);

  // One full-precision signed product per MAC cycle.
  assign prod = smp[cnt] * coef[cnt];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)     state_nx = MAC;
      MAC:     if (cnt == LAST_TAP)  state_nx = SAVE;
      SAVE:                          state_nx = HOLD;
      HOLD:    if (bus.out_ready)    state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output scaling: optional round-half-up, arithmetic shift, then clamp.
  // The extra top bit keeps the rounding add from wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_shift = {acc[ACC_W-1], acc};
`ifdef FIR_STREAM_ROUND_EN
    pre_shift = pre_shift + RND_HALF;
`endif
    scaled = pre_shift >>> FRAC;
    if (scaled > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_val = scaled[DATA_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: delay line, coefficient bank, accumulator, output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      // NOTE: the delay line and coefficient bank are flops, not RAM, and are
      // cleared here so a reset always restarts the filter from silence with
      // a zero response; this is why they sit in a resettable process.
      for (int i = 0; i < TAPS; i++) begin
        smp[i]  <= '0;
        coef[i] <= '0;
      end
      acc           <= '0;
      cnt           <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (coef_wr) begin
        coef[bus.coef_addr] <= bus.coef_data;
      end

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            smp[0] <= bus.in_data;
            for (int i = 1; i < TAPS; i++) begin
              smp[i] <= smp[i-1];
            end
            acc <= '0;
            cnt <= '0;
          end
        end

        MAC: begin
          acc <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
          // Counter parks on the last tap; it is only rewound on entry.
          if (cnt != LAST_TAP) begin
            cnt <= cnt + AW'(1);
          end
        end

        SAVE: begin
          bus.out_data  <= sat_val;
          bus.out_valid <= 1'b1;
        end

        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream.sv
// -----------------------------------------------------------------------------
// tb_fir_stream
//
// Directed bench for fir_stream with default parameters (16 taps, Q1.15
// coefficients, FRAC=15). Expected results are hand-computed constants.
// Honors FIR_STREAM_ROUND_EN for the rounding scenario.
// -----------------------------------------------------------------------------
module tb_fir_stream;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 16;
  localparam int FRAC   = 15;
  localparam int AW     = $clog2(TAPS);

  logic ck = 1'b0;
  logic rst_n;
  logic busy;

  int n_tests    = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int accept_cyc = 0;

  fir_stream_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) bus ();

  fir_stream #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS),
    .FRAC  (FRAC)
  ) dut (
    .ck   (ck),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside, except bounded-wait timeouts)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_coef(input int addr, input int data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AW'(addr);
    bus.coef_data = COEF_W'(data);
    step();
    bus.coef_we   = 1'b0;
  endtask

  task automatic accept(input int d);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b, want 1", bus.in_ready);
    end
    bus.in_data  = DATA_W'(d);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    accept_cyc   = cyc;
  endtask

  task automatic wait_out(output int lat, output logic signed [DATA_W-1:0] res,
                          output bit busy_ok);
    lat     = -1;
    res     = '0;
    busy_ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (bus.out_valid) begin
        lat = cyc - accept_cyc;
        res = bus.out_data;
        break;
      end
      if (!busy || bus.in_ready) busy_ok = 1'b0;
      step();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_tests++;
    if (bus.out_data !== 16'sd0) begin
      n_fail++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_gain();
    int lat; logic signed [DATA_W-1:0] res; bit bok;
    do_reset();
    write_coef(0, 16384);
    accept(1000);
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== 16'sd500) begin
      n_fail++; $display("FAIL gain_data: got %0d want 500", res);
    end
    n_tests++;
    if (lat !== 17) begin
      n_fail++; $display("FAIL gain_latency: got %0d want 17", lat);
    end
    n_tests++;
    if (bok !== 1'b1) begin
      n_fail++; $display("FAIL gain_busy: busy/in_ready ok=%b want 1", bok);
    end
  endtask

  task automatic test_simultaneous();
    int lat; logic signed [DATA_W-1:0] res; bit bok;
    do_reset();
    bus.coef_we   = 1'b1;
    bus.coef_addr = '0;
    bus.coef_data = 16'sd16384;
    bus.in_data   = 16'sd1000;
    bus.in_valid  = 1'b1;
    step();
    bus.coef_we  = 1'b0;
    bus.in_valid = 1'b0;
    accept_cyc   = cyc;
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== 16'sd500) begin
      n_fail++; $display("FAIL simul_write_data: got %0d want 500", res);
    end
  endtask

  task automatic test_impulse();
    int lat; logic signed [DATA_W-1:0] res; bit bok;
    logic signed [DATA_W-1:0] exp_v;
    int prev;
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 1000 * (k + 1));
    prev = 0;
    for (int j = 0; j < TAPS; j++) begin
      accept((j == 0) ? 16384 : 0);
      if (j > 0) begin
        n_tests++;
        if (accept_cyc - prev !== 19) begin
          n_fail++;
          $display("FAIL impulse_period[%0d]: got %0d want 19", j, accept_cyc - prev);
        end
      end
      prev = accept_cyc;
      wait_out(lat, res, bok);
      exp_v = DATA_W'(500 * (j + 1));
      n_tests++;
      if (res !== exp_v) begin
        n_fail++; $display("FAIL impulse_out[%0d]: got %0d want %0d", j, res, exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    int lat; logic signed [DATA_W-1:0] res; bit bok;
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int j = 0; j < TAPS; j++) begin
      accept(32767);
      wait_out(lat, res, bok);
    end
    n_tests++;
    if (res !== 16'sd32767) begin
      n_fail++; $display("FAIL sat_pos: got %0d want 32767", res);
    end
    for (int j = 0; j < TAPS; j++) begin
      accept(-32768);
      wait_out(lat, res, bok);
    end
    n_tests++;
    if (res !== -16'sd32768) begin
      n_fail++; $display("FAIL sat_neg: got %0d want -32768", res);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic signed [DATA_W-1:0] res; bit bok;
    do_reset();
    write_coef(0, 16384);
    write_coef(1, 16384);
    bus.out_ready = 1'b0;
    accept(2000);
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== 16'sd1000) begin
      n_fail++; $display("FAIL bp_first: got %0d want 1000", res);
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 16'sd30000;
      step();
      n_tests++;
      if (bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid);
      end
      n_tests++;
      if (bus.out_data !== 16'sd1000) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %0d want 1000", i, bus.out_data);
      end
      n_tests++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid);
    end
    // Delay line must hold 0, 2000: the ignored 30000 pulses never shifted in.
    accept(0);
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== 16'sd1000) begin
      n_fail++; $display("FAIL bp_not_queued: got %0d want 1000", res);
    end
  endtask

  task automatic test_busy_write();
    int lat; logic signed [DATA_W-1:0] res; bit bok;
    do_reset();
    write_coef(0, 16384);
    accept(1000);
    step();
    step();
    bus.coef_we   = 1'b1;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    step();
    bus.coef_we = 1'b0;
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== 16'sd500) begin
      n_fail++; $display("FAIL busy_write_data: got %0d want 500", res);
    end
    n_tests++;
    if (lat !== 17) begin
      n_fail++; $display("FAIL busy_write_latency: got %0d want 17", lat);
    end
    accept(1000);
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== 16'sd500) begin
      n_fail++; $display("FAIL busy_write_dropped: got %0d want 500", res);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic signed [DATA_W-1:0] res; bit bok;
    bit seen;
    do_reset();
    write_coef(0, 16384);
    accept(1000);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_busy: got %b want 0", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_output: out_valid seen=%b want 0", seen);
    end
    accept(1000);
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== 16'sd0) begin
      n_fail++; $display("FAIL midrst_coef_cleared: got %0d want 0", res);
    end
    n_tests++;
    if (lat !== 17) begin
      n_fail++; $display("FAIL midrst_latency: got %0d want 17", lat);
    end
  endtask

  task automatic test_rounding();
    int lat; logic signed [DATA_W-1:0] res; bit bok;
    logic signed [DATA_W-1:0] exp_pos;
    logic signed [DATA_W-1:0] exp_neg;
`ifdef FIR_STREAM_ROUND_EN
    exp_pos = 16'sd1;
    exp_neg = 16'sd0;
`else
    exp_pos = 16'sd0;
    exp_neg = -16'sd1;
`endif
    do_reset();
    write_coef(0, 1);
    accept(16384);
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== exp_pos) begin
      n_fail++; $display("FAIL round_pos: got %0d want %0d", res, exp_pos);
    end
    accept(-16384);
    wait_out(lat, res, bok);
    n_tests++;
    if (res !== exp_neg) begin
      n_fail++; $display("FAIL round_neg: got %0d want %0d", res, exp_neg);
    end
  endtask

  initial begin
    test_reset();
    test_gain();
    test_simultaneous();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_busy_write();
    test_reset_mid();
    test_rounding();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_stream.md
Name: fir_stream

Overview:
- Parametrised, runtime-programmable single-channel FIR filter.
- Uses one time-shared multiplier-accumulator and valid/ready handshakes on both input and output streams.
- Next-generation filter block for the audio/DSP datapath: configurable width and tap count, coefficients written over a register port, saturating output, output held under backpressure.

Parameters:
- DATA_W, 16, sample width (signed in and out).
- COEF_W, 16, coefficient width (signed, Q1.(COEF_W-1)).
- TAPS, 16, number of taps; must be at least 2.
- FRAC, 15, right shift applied to the accumulator to form the output.
- Localparams:
  - AW = $clog2(TAPS)
  - ACC_W = DATA_W+COEF_W+AW

Ports:
- ck  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  DATA_W  signed filtered sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index.
- coef_data  in  COEF_W  signed coefficient value.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - All TAPS sample registers, all coefficients, accumulator and tap counter are cleared to 0.
  - out_data=0, out_valid=0.
  - Applies in any state, mid-computation included; no partial result is ever emitted.
- States: IDLE, MAC, SAVE, HOLD.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid at an edge: samples shift (s[i]<=s[i-1], s[0]<=in_data), accumulator cleared, counter=0, go to MAC.
- MAC:
  - Each cycle, acc <= acc + s[cnt]*coef[cnt], full-precision signed, ACC_W wide; cnt increments.
  - When cnt==TAPS-1, go to SAVE. MAC lasts exactly TAPS cycles.
- SAVE:
  - out_data <= sat(acc >>> FRAC), arithmetic shift.
  - out_valid <= 1; go to HOLD.
- HOLD:
  - out_valid=1; out_data stable.
  - On out_ready at an edge: out_valid <= 0, go to IDLE.
- Latency: sample accepted at edge E, out_valid first high after edge E+TAPS+1. With TAPS=16, that is 17 cycles.
- Minimum throughput period is TAPS+3 cycles when out_ready is held high.
- in_ready=0 in MAC, SAVE and HOLD. in_valid in those states is ignored and never queued.
- sat(x): clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; otherwise take the low DATA_W bits.
- Coefficient writes:
  - Take effect at the edge only when state is IDLE.
  - Writes while busy=1 are dropped; the result uses the old coefficients.
  - coef_addr >= TAPS is ignored.
- Simultaneous coef_we and in_valid in IDLE: the write lands first, so the accepted sample's computation uses the new coefficient.
- The tap counter wraps only through reset to 0 on entering MAC; it never exceeds TAPS-1.

Optional Feature:
- Macro FIR_STREAM_ROUND_EN.
- Defined: SAVE uses sat((acc + 2^(FRAC-1)) >>> FRAC), round half up; the addition is ACC_W+1 wide so it cannot overflow.
- Undefined: plain truncation toward minus infinity, as in SAVE above.
- Latency and the handshake are identical in both builds.

Test Plan:
- Gain: after reset, write coef[0]=16384 (others 0), send 1000 -> out_data=500, out_valid exactly 17 cycles after acceptance, busy=1 throughout.
- Impulse response: coef[k]=1000*(k+1), send 16384 then 15 zeros with out_ready=1 -> outputs 500,1000,1500,...,8000 in order.
- Saturation:
  - All coefs 32767, 16 samples of 32767 -> final out 32767.
  - Repeat with -32768 samples -> final out -32768.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in HOLD -> out_valid=1 and out_data constant; in_ready=0; in_valid pulses ignored.
  - Raise out_ready -> in_ready=1 next cycle.
- Busy write and reset:
  - Write coef[0]=0 during MAC -> result uses the old coef.
  - Assert rst_n=0 in MAC cycle 5 -> out_valid stays 0, in_ready=1 after release; next input 1000 -> out 0, since coefficients were cleared.
- Rounding: coef[0]=1, input 16384 -> out 0 without FIR_STREAM_ROUND_EN, out 1 with it.
